// File: rtl/mtl_frame_scheduler.sv
// Double-buffered frame scheduler: requests image loads into the back buffer and swaps at end of frame.
// Optional macro MTL_SCHED_WRAP_EN makes gestures wrap around the image ring instead of being dropped.
module mtl_frame_scheduler #(
   parameter int unsigned NUM_IMG      = 8,
   parameter int unsigned IDX_W        = 3,
   parameter int unsigned LOAD_TIMEOUT = 32'd4194304
) (
   input  logic             iCLK,
   input  logic             iRST_n,
   input  logic             iEnd_Frame,
   input  logic             iGest_E,
   input  logic             iGest_W,
   input  logic             iLoad_Done,
   output logic             oLoad_Req,
   output logic [IDX_W-1:0] oLoad_Idx,
   output logic             oLoad_Buf,
   output logic             oDisp_Buf,
   output logic [IDX_W-1:0] oDisp_Idx,
   output logic             oLoading,
   output logic             oErr
);

   localparam int unsigned CNT_W = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IMG - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);
`ifdef MTL_SCHED_WRAP_EN
   localparam logic WRAP_EN = 1'b1;
`else
   localparam logic WRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {BOOT, IDLE, REQ, LOAD, WAIT_EOF} state_t;

   state_t           state, state_d;
   logic             load_req, load_req_d;
   logic [IDX_W-1:0] load_idx, load_idx_d;
   logic             load_buf, load_buf_d;
   logic             disp_buf, disp_buf_d;
   logic [IDX_W-1:0] disp_idx, disp_idx_d;
   logic             loading, loading_d;
   logic             err, err_d;
   logic             pend_valid, pend_valid_d;
   logic             pend_east, pend_east_d;
   logic [CNT_W-1:0] cnt, cnt_d;

   logic             gest_one;
   logic             sel_valid, sel_east, sel_ok;
   logic [IDX_W-1:0] sel_idx;

   assign gest_one = iGest_E ^ iGest_W;

   // Neighbour selection: a live gesture beats the pending one; targets always use the shown index
   always_comb begin
      sel_valid = 1'b0;
      sel_east  = 1'b0;
      if (gest_one) begin
         sel_valid = 1'b1;
         sel_east  = iGest_E;
      end else if (pend_valid) begin
         sel_valid = 1'b1;
         sel_east  = pend_east;
      end
      if (sel_east) begin
         sel_ok  = (disp_idx != LAST_IDX) || WRAP_EN;
         sel_idx = (disp_idx == LAST_IDX) ? '0 : disp_idx + IDX_W'(1);
      end else begin
         sel_ok  = (disp_idx != '0) || WRAP_EN;
         sel_idx = (disp_idx == '0) ? LAST_IDX : disp_idx - IDX_W'(1);
      end
   end

   always_comb begin
      state_d      = state;
      load_req_d   = 1'b0;
      load_idx_d   = load_idx;
      load_buf_d   = load_buf;
      disp_buf_d   = disp_buf;
      disp_idx_d   = disp_idx;
      loading_d    = loading;
      err_d        = err;
      pend_valid_d = pend_valid;
      pend_east_d  = pend_east;
      cnt_d        = cnt;

      if (state != IDLE && gest_one) begin
         pend_valid_d = 1'b1;
         pend_east_d  = iGest_E;
      end

      case (state)
         BOOT: begin
            state_d    = REQ;
            load_req_d = 1'b1;
            load_idx_d = '0;
            cnt_d      = '0;
         end
         IDLE: begin
            if (sel_valid) begin
               if (sel_ok) begin
                  state_d      = REQ;
                  load_req_d   = 1'b1;
                  load_idx_d   = sel_idx;
                  cnt_d        = '0;
                  pend_valid_d = 1'b0;
               end else if (!gest_one) begin
                  // an unreachable pending target is consumed; a dropped live gesture leaves it alone
                  pend_valid_d = 1'b0;
               end
            end
         end
         REQ: begin
            state_d = LOAD;
            cnt_d   = cnt + CNT_W'(1);
         end
         LOAD: begin
            if (iLoad_Done) begin
               state_d = WAIT_EOF;
            end else if (cnt == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         WAIT_EOF: begin
            if (iEnd_Frame) begin
               disp_buf_d = ~disp_buf;
               load_buf_d = disp_buf;
               disp_idx_d = load_idx;
               loading_d  = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state      <= BOOT;
         load_req   <= 1'b0;
         load_idx   <= '0;
         load_buf   <= 1'b1;
         disp_buf   <= 1'b0;
         disp_idx   <= '0;
         loading    <= 1'b1;
         err        <= 1'b0;
         pend_valid <= 1'b0;
         pend_east  <= 1'b0;
         cnt        <= '0;
      end else begin
         state      <= state_d;
         load_req   <= load_req_d;
         load_idx   <= load_idx_d;
         load_buf   <= load_buf_d;
         disp_buf   <= disp_buf_d;
         disp_idx   <= disp_idx_d;
         loading    <= loading_d;
         err        <= err_d;
         pend_valid <= pend_valid_d;
         pend_east  <= pend_east_d;
         cnt        <= cnt_d;
      end
   end

   assign oLoad_Req = load_req;
   assign oLoad_Idx = load_idx;
   assign oLoad_Buf = load_buf;
   assign oDisp_Buf = disp_buf;
   assign oDisp_Idx = disp_idx;
   assign oLoading  = loading;
   assign oErr      = err;

endmodule

// File: tb/tb_mtl_frame_scheduler.sv
// Randomized scoreboard bench for mtl_frame_scheduler; a monitor thread checks load requests and buffer swaps.
module tb_mtl_frame_scheduler;
   localparam int unsigned NUM_IMG = 8;
   localparam int unsigned IDX_W   = 3;
   localparam int unsigned TMO     = 16;
`ifdef MTL_SCHED_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic             iCLK = 1'b0;
   logic             iRST_n = 1'b1;
   logic             iEnd_Frame = 1'b0;
   logic             iGest_E = 1'b0;
   logic             iGest_W = 1'b0;
   logic             iLoad_Done = 1'b0;
   logic             oLoad_Req;
   logic [IDX_W-1:0] oLoad_Idx;
   logic             oLoad_Buf;
   logic             oDisp_Buf;
   logic [IDX_W-1:0] oDisp_Idx;
   logic             oLoading;
   logic             oErr;

   mtl_frame_scheduler #(.NUM_IMG(NUM_IMG), .IDX_W(IDX_W), .LOAD_TIMEOUT(TMO)) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .iEnd_Frame(iEnd_Frame), .iGest_E(iGest_E),
      .iGest_W(iGest_W), .iLoad_Done(iLoad_Done), .oLoad_Req(oLoad_Req),
      .oLoad_Idx(oLoad_Idx), .oLoad_Buf(oLoad_Buf), .oDisp_Buf(oDisp_Buf),
      .oDisp_Idx(oDisp_Idx), .oLoading(oLoading), .oErr(oErr)
   );

   always #5 iCLK = ~iCLK;

   typedef struct { int idx; int lbuf; } req_t;
   typedef struct { int dbuf; int idx; } swap_t;
   req_t  req_q[$];
   swap_t swap_q[$];

   int total = 0;
   int bad   = 0;

   // reference model: what the viewer should see, in plain terms
   int m_disp_idx, m_load_idx;
   bit m_disp_buf, m_loading, m_err, m_pend, m_pend_e;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int step_target(input int cur, input bit east);
      if (east) return (cur == NUM_IMG - 1) ? (WRAP ? 0 : -1) : cur + 1;
      return (cur == 0) ? (WRAP ? NUM_IMG - 1 : -1) : cur - 1;
   endfunction

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic drive(input bit e, input bit w, input bit d, input bit f);
      iGest_E = e; iGest_W = w; iLoad_Done = d; iEnd_Frame = f;
      tick();
      iGest_E = 1'b0; iGest_W = 1'b0; iLoad_Done = 1'b0; iEnd_Frame = 1'b0;
   endtask

   task automatic issue_req(input int t);
      req_q.push_back('{t, int'(!m_disp_buf)});
      m_load_idx = t;
   endtask

   task automatic do_reset();
      iRST_n = 1'b0;
      #2;
      check("rst_load_req", oLoad_Req, 0);
      check("rst_load_idx", oLoad_Idx, 0);
      check("rst_load_buf", oLoad_Buf, 1);
      check("rst_disp_buf", oDisp_Buf, 0);
      check("rst_disp_idx", oDisp_Idx, 0);
      check("rst_loading", oLoading, 1);
      check("rst_err", oErr, 0);
      req_q.delete();
      swap_q.delete();
      m_disp_idx = 0; m_load_idx = 0; m_disp_buf = 0; m_loading = 1;
      m_err = 0; m_pend = 0; m_pend_e = 0;
      tick();
      tick();
      iRST_n = 1'b1;
   endtask

   task automatic rand_busy_gest(output bit e, output bit w);
      int r;
      r = $urandom_range(0, 15);
      e = (r <= 1) || (r == 3);
      w = (r == 2) || (r == 3);
      if (e ^ w) begin
         m_pend = 1'b1;
         m_pend_e = e;
      end
   endtask

   // first IDLE cycle: a pending gesture turns into a request from the freshly shown index
   task automatic idle_entry(output bit go);
      int t;
      go = 1'b0;
      if (m_pend) begin
         m_pend = 1'b0;
         t = step_target(m_disp_idx, m_pend_e);
         if (t >= 0) begin
            issue_req(t);
            go = 1'b1;
            drive(0, 0, 0, 0);
         end
      end
   endtask

   // entered in the cycle oLoad_Req should be high; leaves in a known IDLE or REQ cycle
   task automatic run_load(output bit go);
      bit to, coin, e, w, d, f;
      int nd, m;
      check("req_pulse", oLoad_Req, 1);
      to   = ($urandom_range(0, 9) == 0);
      nd   = $urandom_range(1, TMO - 2);
      coin = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < TMO; c++) begin
         if (to && c == TMO - 1) check("err_before_timeout", oErr, m_err);
         rand_busy_gest(e, w);
         d = !to && (c == nd);
         f = d ? coin : ($urandom_range(0, 7) == 0);
         drive(e, w, d, f);
         if (d) break;
      end
      if (to) begin
         m_err = 1'b1;
         check("err_at_timeout", oErr, 1);
         check("timeout_disp_buf", oDisp_Buf, m_disp_buf);
         check("timeout_disp_idx", oDisp_Idx, m_disp_idx);
         check("timeout_loading", oLoading, m_loading);
      end else begin
         check("load_idx_hold", oLoad_Idx, m_load_idx);
         m = $urandom_range(0, 4);
         for (int i = 0; i < m; i++) begin
            rand_busy_gest(e, w);
            drive(e, w, $urandom_range(0, 3) == 0, 0);
         end
         rand_busy_gest(e, w);
         swap_q.push_back('{int'(!m_disp_buf), m_load_idx});
         m_disp_buf = !m_disp_buf;
         m_disp_idx = m_load_idx;
         m_loading  = 1'b0;
         drive(e, w, 0, 1);
         check("swap_disp_buf", oDisp_Buf, m_disp_buf);
         check("swap_disp_idx", oDisp_Idx, m_disp_idx);
         check("swap_loading", oLoading, 0);
         check("swap_load_buf", oLoad_Buf, int'(!m_disp_buf));
      end
      idle_entry(go);
   endtask

   // monitor: every request and every buffer swap must match the next scoreboard entry
   task automatic monitor();
      int    pb, pi;
      req_t  r;
      swap_t s;
      pb = 0; pi = 0;
      forever begin
         @(negedge iCLK);
         if (!iRST_n) begin
            pb = oDisp_Buf; pi = oDisp_Idx;
         end else begin
            if (oLoad_Req) begin
               if (req_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL stray_req: got request idx %0d expected none (t=%0t)", oLoad_Idx, $time);
               end else begin
                  r = req_q.pop_front();
                  check("req_idx", oLoad_Idx, r.idx);
                  check("req_buf", oLoad_Buf, r.lbuf);
               end
            end
            if (int'(oDisp_Buf) != pb) begin
               if (swap_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL stray_swap: got swap to idx %0d expected none (t=%0t)", oDisp_Idx, $time);
               end else begin
                  s = swap_q.pop_front();
                  check("mon_swap_buf", oDisp_Buf, s.dbuf);
                  check("mon_swap_idx", oDisp_Idx, s.idx);
               end
            end else if (int'(oDisp_Idx) != pi) begin
               total++; bad++;
               $display("FAIL idx_without_swap: got idx %0d expected %0d (t=%0t)", oDisp_Idx, pi, $time);
            end
            pb = oDisp_Buf; pi = oDisp_Idx;
         end
      end
   endtask

   initial begin
      bit go, e, w;
      int t, k, r;
      fork
         monitor();
      join_none
      #1;
      do_reset();
      issue_req(0);
      drive(0, 0, 0, 0);
      go = 1'b1;
      while (go) run_load(go);

      for (int ep = 0; ep < 80; ep++) begin
         k = $urandom_range(0, 3);
         for (int i = 0; i < k; i++) drive(0, 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         r = $urandom_range(0, 9);
         e = (r <= 5) || (r == 9);
         w = (r >= 6);
         go = 1'b0;
         if (e ^ w) begin
            t = step_target(m_disp_idx, e);
            if (t >= 0) begin
               issue_req(t);
               go = 1'b1;
            end
         end
         drive(e, w, 0, 0);
         if (go) begin
            while (go) run_load(go);
         end else begin
            check("dropped_gesture_no_req", oLoad_Req, 0);
            for (int i = 0; i < 8; i++) drive(0, 0, 0, 0);
         end
      end

      // reset in the middle of a load, then a late done must not count
      do_reset();
      issue_req(0);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0);
      do_reset();
      issue_req(0);
      drive(0, 0, 1, 0);
      check("boot_req_after_reset", oLoad_Req, 1);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 1);
      drive(0, 0, 1, 0);
      swap_q.push_back('{1, 0});
      m_disp_buf = 1'b1; m_disp_idx = 0; m_loading = 1'b0;
      drive(0, 0, 0, 1);
      check("first_swap_buf", oDisp_Buf, 1);
      check("first_swap_loading", oLoading, 0);
      check("first_swap_load_buf", oLoad_Buf, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);

      check("req_queue_drained", req_q.size(), 0);
      check("swap_queue_drained", swap_q.size(), 0);
      check("final_err", oErr, m_err);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mtl_frame_scheduler.md
MTL_FRAME_SCHEDULER -- requirements
Module: mtl_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_IMG, 8, number of images stored in SDRAM (2..2^IDX_W).
REQ-002 SHALL have parameter IDX_W, 3, image index width.
REQ-003 SHALL have parameter LOAD_TIMEOUT, 2^22, iCLK cycles allowed per load before abort.
REQ-004 SHALL have one clock and one reset: iCLK (single clock); iRST_n (asynchronous, active-low).
REQ-005 SHALL have port iCLK  in  1  33 MHz control clock, same as display control clock.
REQ-006 SHALL have port iRST_n  in  1  async active-low reset.
REQ-007 SHALL have port iEnd_Frame  in  1  one-cycle pulse at end of LCD frame.
REQ-008 SHALL have port iGest_E / iGest_W  in  1 each  one-cycle gesture pulses, already in iCLK domain.
REQ-009 SHALL have port iLoad_Done  in  1  one-cycle pulse, loader finished writing back buffer.
REQ-010 SHALL have port oLoad_Req  out  1  one-cycle load request to image loader.
REQ-011 SHALL have port oLoad_Idx  out  IDX_W  image index to load, stable from oLoad_Req until iLoad_Done or abort.
REQ-012 SHALL have port oLoad_Buf  out  1  SDRAM buffer to write, always ~oDisp_Buf.
REQ-013 SHALL have port oDisp_Buf / oDisp_Idx  out  1 / IDX_W  front buffer and image shown.
REQ-014 SHALL have port oLoading  out  1  drives display iLoading; high until first image shown.
REQ-015 SHALL have port oErr  out  1  sticky load-timeout flag.

Function
REQ-016 SHALL implement FSM states BOOT, IDLE, REQ, LOAD, WAIT_EOF.
REQ-017 BOOT SHALL go to REQ next cycle with target index 0.
REQ-018 IDLE SHALL go to REQ on a valid gesture, or on a pending gesture: E gives target oDisp_Idx+1, W gives oDisp_Idx-1.
REQ-019 REQ SHALL assert oLoad_Req for exactly that one cycle, latch oLoad_Idx=target, clear timeout counter, go LOAD; a gesture sampled in IDLE gives oLoad_Req on the next cycle.
REQ-020 LOAD SHALL go to WAIT_EOF on iLoad_Done.
REQ-021 LOAD SHALL, on counter reaching LOAD_TIMEOUT-1, set oErr and go IDLE without swap or other output change.
REQ-022 WAIT_EOF SHALL, on iEnd_Frame, toggle oDisp_Buf, set oDisp_Idx=oLoad_Idx, clear oLoading (all visible next cycle), go IDLE.
REQ-023 iLoad_Done and iEnd_Frame in the same LOAD cycle SHALL NOT swap; swap waits for the next iEnd_Frame.
REQ-024 iLoad_Done outside LOAD SHALL be ignored.
REQ-025 Gestures in REQ/LOAD/WAIT_EOF SHALL be held in a one-deep pending register; the latest gesture overwrites.
REQ-026 Pending target SHALL be computed from oDisp_Idx at IDLE entry, not at capture time.
REQ-027 iGest_E and iGest_W in the same cycle SHALL be ignored and SHALL NOT clear pending.
REQ-028 Index arithmetic SHALL be modulo-free compare, never producing a value >= NUM_IMG.
REQ-029 Out-of-range gesture SHALL follow the Configuration rules.

Reset
REQ-030 On iRST_n low, SHALL asynchronously enter BOOT and set oLoad_Req=0, oLoad_Idx=0, oLoad_Buf=1, oDisp_Buf=0, oDisp_Idx=0, oLoading=1, oErr=0, pending empty, counter 0.
REQ-031 Reset mid-load SHALL abandon the load; a late iLoad_Done after reset SHALL be ignored.

Configuration
REQ-032 With macro MTL_SCHED_WRAP_EN defined, E at NUM_IMG-1 SHALL target 0 and W at 0 SHALL target NUM_IMG-1.
REQ-033 Without MTL_SCHED_WRAP_EN, such gestures SHALL be dropped: no oLoad_Req, state stays IDLE, pending unchanged.

Verification
REQ-034 Release reset, iLoad_Done 100 cycles after oLoad_Req, then iEnd_Frame -> oLoad_Idx=0, oLoad_Buf=1; after swap oDisp_Buf=1, oLoading=0.
REQ-035 In IDLE with oDisp_Idx=2, pulse iGest_E -> oLoad_Req next cycle, oLoad_Idx=3, oLoad_Buf=0; after done+EOF oDisp_Idx=3.
REQ-036 During LOAD pulse iGest_W then iGest_E -> after swap to 3 a second request with oLoad_Idx=4.
REQ-037 Idx=7, NUM_IMG=8, iGest_E -> with macro oLoad_Idx=0; without macro no oLoad_Req for 1000 cycles.
REQ-038 LOAD_TIMEOUT=16, never assert iLoad_Done -> oErr=1 at cycle 16 after REQ, oDisp_Buf unchanged, then next gesture is accepted.
REQ-039 iLoad_Done coincident with iEnd_Frame -> no swap that frame; swap on the following iEnd_Frame.
